// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types and pattern-analysis helpers for seq_detect_fsm.
//   MAX_PAT_LEN / MAX_STATE_W : largest supported pattern and its state width.
//   pat_bit()     : bit of a pattern at a run-time index.
//   next_state()  : KMP advance/fallback for one consumed bit.
//   border_len()  : longest proper prefix that is also a suffix.
// Patterns are passed zero-extended to MAX_PAT_LEN with the live length, so a
// run-time pattern is analysed exactly like a DEF_PATTERN.
package seq_detect_pkg;

  localparam int MAX_PAT_LEN = 16;
  localparam int MAX_STATE_W = $clog2(MAX_PAT_LEN);

  typedef logic [MAX_PAT_LEN-1:0] pat_t;

  // A shift keeps the run-time index free of select-width concerns.
  function automatic logic pat_bit(input pat_t pat, input int idx);
    pat_t sh;
    sh = pat >> idx;
    return sh[0];
  endfunction

  // Largest k < pat_len such that (first `state` pattern bits, then a) ends in
  // the pattern's k-bit prefix. Covers the advance, the mismatch fallback and
  // the post-hit border in one rule; pattern bit 0 of the prefix is the MSB.
  function automatic int next_state(input pat_t pat, input int state,
                                    input logic a, input int pat_len);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k < MAX_PAT_LEN; k++) begin
      if (k < pat_len && k <= state + 1) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
          if (i < k) begin
            j  = state + 1 - k + i;
            sb = (j == state) ? a : pat_bit(pat, pat_len - 1 - j);
            if (sb != pat_bit(pat, pat_len - 1 - i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border_len(input pat_t pat, input int pat_len);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < MAX_PAT_LEN; k++) begin
      if (k < pat_len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
          if (i < k && pat_bit(pat, pat_len - 1 - i) != pat_bit(pat, k - 1 - i))
            ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, reset : rising-edge clock, synchronous active-high reset.
//   inc        : count one event (ignored once saturated).
//   clr        : clear; with inc in the same cycle the result is 1.
//   count      : current count.    sat : count is all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = &count;

  // NOTE: sequential state is written only with <= so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector with runtime pattern/overlap config.
//   clk, reset   : rising-edge clock, synchronous active-high reset.
//   en, a        : sample enable and serial data bit.
//   cfg_load     : load cfg_pattern (MSB first) and cfg_overlap; restarts search.
//   clr_cnt      : clear the hit counter.
//   state        : matched-prefix length 0..PAT_LEN-1.
//   match        : registered one-cycle hit pulse.
//   match_cnt    : saturating hit count.   cnt_sat : match_cnt is all-ones.
// PAT_LEN must lie in 2..MAX_PAT_LEN.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_LEN-1:0] DEF_PATTERN = 4'b1011,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       a,
  input  logic                       cfg_load,
  input  logic [PAT_LEN-1:0]         cfg_pattern,
  input  logic                       cfg_overlap,
  input  logic                       clr_cnt,
  output logic [$clog2(PAT_LEN)-1:0] state,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       cnt_sat
);

  localparam int STATE_W = $clog2(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q;
  logic               overlap_q;
  logic [STATE_W-1:0] state_q;
  logic               match_q;

  pat_t               pat_ext;
  logic               exp_bit;
  logic               hit;
  logic [STATE_W-1:0] fall_state;
  logic [STATE_W-1:0] border_state;

  assign pat_ext = pat_t'(pat_q);

  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally), so no latch can be inferred.
  always_comb begin
    exp_bit      = pat_bit(pat_ext, PAT_LEN - 1 - int'(state_q));
    hit          = en && !cfg_load && (a == exp_bit) &&
                   (int'(state_q) == PAT_LEN - 1);
    fall_state   = STATE_W'(next_state(pat_ext, int'(state_q), a, PAT_LEN));
    border_state = STATE_W'(border_len(pat_ext, PAT_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      match_q   <= 1'b0;
      pat_q     <= DEF_PATTERN;
      overlap_q <= DEF_OVERLAP;
    end else if (cfg_load) begin
      // The bit presented with a load belongs to neither pattern: drop it.
      pat_q     <= cfg_pattern;
      overlap_q <= cfg_overlap;
      state_q   <= '0;
      match_q   <= 1'b0;
    end else if (en) begin
      match_q <= hit;
      if (hit) state_q <= overlap_q ? border_state : '0;
      else     state_q <= fall_state;
    end else begin
      match_q <= 1'b0;
    end
  end

  assign state = state_q;
  assign match = match_q;

  // Reset dominates inside the counter, so a hit coinciding with reset
  // is never counted.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (clr_cnt),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: two instances (CNT_W=8 and CNT_W=2) share all
// inputs; a history-queue model predicts state, match and both counters.
module tb_seq_detect_fsm;

  localparam int         PAT_LEN = 4;
  localparam logic [3:0] DEF_PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       reset, en, a, cfg_load, cfg_overlap, clr_cnt;
  logic [3:0] cfg_pattern;
  logic [1:0] state, state_s;
  logic       match, match_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;
  logic       cnt_sat, cnt_sat_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(
    .PAT_LEN(PAT_LEN), .CNT_W(8), .DEF_PATTERN(DEF_PAT), .DEF_OVERLAP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .state(state), .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_fsm #(
    .PAT_LEN(PAT_LEN), .CNT_W(2), .DEF_PATTERN(DEF_PAT), .DEF_OVERLAP(1'b1)
  ) dut_s (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .state(state_s), .match(match_s), .match_cnt(match_cnt_s), .cnt_sat(cnt_sat_s)
  );

  // ---------------- reference model ----------------
  bit         hist[$];   // bits consumed since reset/load/non-overlap hit
  logic [3:0] m_pat = DEF_PAT;
  bit         m_ov = 1'b1;
  bit         m_match = 1'b0;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;

  // Do the last k consumed bits equal the first k pattern bits?
  function automatic bit ends_with(int k);
    int n = hist.size();
    if (n < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (hist[n-k+i] != m_pat[PAT_LEN-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_state();
    for (int k = PAT_LEN - 1; k >= 1; k--)
      if (ends_with(k)) return k;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare every output.
  task automatic step(input bit r, input bit e, input bit b, input bit ld,
                      input logic [3:0] lp, input bit lo, input bit c);
    bit hit;
    reset = r; en = e; a = b; cfg_load = ld;
    cfg_pattern = lp; cfg_overlap = lo; clr_cnt = c;
    @(posedge clk);
    hit = 1'b0;
    if (r) begin
      hist.delete();
      m_pat = DEF_PAT; m_ov = 1'b1; m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_pat = lp; m_ov = lo; hist.delete();
      end else if (e) begin
        hist.push_back(b);
        if (hist.size() > PAT_LEN) void'(hist.pop_front());
        hit = ends_with(PAT_LEN);
        if (hit && !m_ov) hist.delete();
      end
      m_match = hit;
      if (c) begin
        m_cnt8 = hit ? 1 : 0;
        m_cnt2 = hit ? 1 : 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    #1;
    check("state",     state,       model_state());
    check("state_s",   state_s,     model_state());
    check("match",     match,       m_match);
    check("match_s",   match_s,     m_match);
    check("cnt8",      match_cnt,   m_cnt8);
    check("cnt2",      match_cnt_s, m_cnt2);
    check("sat8",      cnt_sat,     m_cnt8 == 255);
    check("sat2",      cnt_sat_s,   m_cnt2 == 3);
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] p, input bit ov, input bit b);
    step(1'b0, 1'b1, b, 1'b1, p, ov, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s7;
    logic [1:0] exp7[7];
    logic [5:0] s6;
    int         hits;

    // 1: reset and overlap chain
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("rst_state", state, 0);
    check("rst_match", match, 0);
    check("rst_cnt",   match_cnt, 0);
    s7 = 7'b1011011;
    exp7 = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6-i]);
      check("t1_state", state, exp7[i]);
      check("t1_match", match, (i == 3 || i == 6));
    end
    check("t1_cnt", match_cnt, 2);

    // 2: non-overlap
    load(4'b1011, 1'b0, 1'b0);
    exp7 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6-i]);
      check("t2_state", state, exp7[i]);
      if (match) hits++;
    end
    check("t2_hits", hits, 1);
    check("t2_cnt", match_cnt, 3);

    // 3: mismatch fallback, then hit with reset to 0
    load(4'b1011, 1'b0, 1'b0);
    s6 = 6'b101011;
    exp7 = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      bit_in(s6[5-i]);
      check("t3_state", state, exp7[i]);
      check("t3_match", match, (i == 5));
    end

    // 4: enable hold, then reset mid-pattern
    load(4'b0110, 1'b1, 1'b0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    check("t4_s3", state, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i[0], 1'b0, 4'b0000, 1'b0, 1'b0);
      check("t4_hold", state, 3);
      check("t4_nomatch", match, 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("t4_rst_state", state, 0);
    check("t4_rst_cnt", match_cnt, 0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    check("t4_defpat", match, 1);

    // 5: saturation (2-bit instance) and clear with hit
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    load(4'b0000, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      bit_in(1'b0);
      check("t5_match", match_s, (i >= 4));
      if (i >= 4) begin
        check("t5_cnt", match_cnt_s, (i >= 6) ? 3 : i - 3);
        check("t5_sat", cnt_sat_s, (i >= 6));
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    check("t5_clr_cnt", match_cnt_s, 1);
    check("t5_clr_sat", cnt_sat_s, 0);

    // 6: config load mid-stream
    load(4'b1011, 1'b1, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    check("t6_s2", state, 2);
    load(4'b0110, 1'b1, 1'b1);
    check("t6_load", state, 0);
    s7 = 7'b0110110;
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6-i]);
      check("t6_match", match, (i == 3 || i == 6));
    end

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           1'($urandom),
           $urandom_range(0, 39) == 0,
           4'($urandom),
           1'($urandom),
           $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
